control_sequencer: RTL and testbench

- Multi-cycle Moore control unit that drives the control inputs of the CPU datapath.
- Fetches through PC/MAR/MDR/IR, decodes IR[31:27], and steps through T-states emitting bus-enable, register-load, ALU-op and memory strobes.
- Register-file selection uses select-and-encode (Gra/Grb/Grc plus Rin/Rout); the downstream encoder expands these to R0in..R15in / R0out..R15out.

---
 rtl/control_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle Moore control unit for the CPU datapath.
// Fetches through PC/MAR/MDR/IR, decodes IR[31:27] in T3 and steps through
// the class-specific T-states, driving datapath strobes, select-and-encode
// register controls, the ALU opcode and the memory strobes.
//
// Ports:
//   clock          rising-edge clock
//   clear          asynchronous active-low reset (FSM -> RST, fault cleared)
//   IR             instruction register contents (opcode in IR[31 -: OPW])
//   CON            branch condition flag
//   mem_ready      memory data valid / write done, sampled in memory states
//   Stop           halt request, honoured in the last state of an instruction
//   PCout..Zhighout, HIin, LOin    datapath strobes
//   Gra/Grb/Grc, Rin/Rout, BAout, Cout, CONin   register select / encode controls
//   Read, Write    memory strobes (Read also steers the MDR mux)
//   alu_op         ALU opcode
//   Run            high while executing (T0..T7)
//   fault          sticky memory-timeout flag
module control_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned OPW          = 5
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [31:0]    IR,
  input  logic           CON,
  input  logic           mem_ready,
  input  logic           Stop,
  output logic           PCout,
  output logic           IncPC,
  output logic           PCin,
  output logic           MARin,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           HIin,
  output logic           LOin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic           Cout,
  output logic           CONin,
  output logic           Read,
  output logic           Write,
  output logic [OPW-1:0] alu_op,
  output logic           Run,
  output logic           fault
);

  localparam int unsigned CntW = $clog2(MEM_WAIT_MAX + 1);

  // T0..T7 must stay consecutive: the sequencer advances by incrementing.
  typedef enum logic [3:0] {
    StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic            fault_q, fault_d;

  logic [OPW-1:0]  opcode;
  logic            unused_ir;
  assign opcode    = IR[31 -: OPW];
  assign unused_ir = ^IR[31-OPW:0];

  // Instruction classes (mutually exclusive).
  logic cls_r, cls_i, cls_ld, cls_st, cls_md, cls_br, cls_halt, cls_nop;
  always_comb begin
    cls_r    = (opcode <= OPW'(8));
    cls_i    = (opcode >= OPW'(9)) && (opcode <= OPW'(11));
    cls_ld   = (opcode == OPW'(12));
    cls_st   = (opcode == OPW'(13));
    cls_md   = (opcode == OPW'(14)) || (opcode == OPW'(15));
    cls_br   = (opcode == OPW'(16));
    cls_halt = (opcode == OPW'(25));
    cls_nop  = !(cls_r || cls_i || cls_ld || cls_st || cls_md || cls_br || cls_halt);
  end

  logic [OPW-1:0] imm_alu;
  always_comb begin
    imm_alu = OPW'(0);
    if (opcode == OPW'(10)) imm_alu = OPW'(2);
    if (opcode == OPW'(11)) imm_alu = OPW'(3);
  end

  logic in_exec, mem_state, last_state;
  always_comb begin
    in_exec    = (state_q != StRst) && (state_q != StHalt);
    mem_state  = (state_q == StT1) || (state_q == StT6 && cls_ld) ||
                 (state_q == StT7 && cls_st);
    last_state = (state_q == StT3 && cls_nop) ||
                 (state_q == StT5 && (cls_r || cls_i)) ||
                 (state_q == StT6 && (cls_md || cls_br)) ||
                 (state_q == StT7 && (cls_ld || cls_st));
  end

  // Next state, wait counter and fault flag.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    if (state_q == StRst) begin
      state_d = StT0;
      wait_d  = '0;
    end else if (in_exec) begin
      if (mem_state && !mem_ready) begin
        // A stall cycle: give up after MEM_WAIT_MAX of them.
        if (wait_q == CntW'(MEM_WAIT_MAX - 1)) begin
          state_d = StHalt;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + CntW'(1);
        end
      end else begin
        // Any advance restarts the counter for the next memory state.
        wait_d = '0;
        if (state_q == StT3 && cls_halt) begin
          state_d = StHalt;
        end else if (last_state) begin
          state_d = Stop ? StHalt : StT0;
        end else begin
          state_d = state_e'(state_q + 4'd1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= StRst;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  // Moore output decode of state and IR (CON only gates the taken-branch PC load).
  always_comb begin
    PCout = 1'b0; IncPC = 1'b0; PCin = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; HIin = 1'b0; LOin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Cout = 1'b0; CONin = 1'b0; Read = 1'b0; Write = 1'b0;
    alu_op = '0;
    Run    = in_exec;
    fault  = fault_q;
    unique case (state_q)
      StT0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      StT1: begin Read = 1'b1; MDRin = 1'b1; end
      StT2: begin MDRout = 1'b1; IRin = 1'b1; end
      StT3: begin
        if (cls_r || cls_i) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (cls_ld || cls_st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (cls_md) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (cls_br) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end
      end
      StT4: begin
        if (cls_r) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
        end else if (cls_i) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = imm_alu;
        end else if (cls_ld || cls_st) begin
          Cout = 1'b1; Zin = 1'b1;
        end else if (cls_md) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
        end else if (cls_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end
      end
      StT5: begin
        if (cls_r || cls_i) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (cls_ld || cls_st) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (cls_md) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else if (cls_br) begin
          Cout = 1'b1; Zin = 1'b1;
        end
      end
      StT6: begin
        if (cls_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (cls_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (cls_md) begin
          Zhighout = 1'b1; HIin = 1'b1;
        end else if (cls_br && CON) begin
          Zlowout = 1'b1; PCin = 1'b1;
        end
      end
      StT7: begin
        if (cls_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (cls_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam int unsigned WaitMax = 15;

  logic clock = 1'b0;
  logic clear = 1'b0;
  logic [31:0] IR = '0;
  logic CON = 1'b0, mem_ready = 1'b0, Stop = 1'b0;
  logic PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout;
  logic HIin, LOin, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, Read, Write, Run, fault;
  logic [4:0] alu_op;

  control_sequencer #(.MEM_WAIT_MAX(WaitMax), .OPW(5)) dut (
    .clock(clock), .clear(clear), .IR(IR), .CON(CON), .mem_ready(mem_ready), .Stop(Stop),
    .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .CONin(CONin), .Read(Read),
    .Write(Write), .alu_op(alu_op), .Run(Run), .fault(fault)
  );

  always #5 clock = ~clock;

  // Bit positions in the observed output word.
  localparam int PCOUT = 0, INCPC = 1, PCIN = 2, MARIN = 3, MDRIN = 4, MDROUT = 5;
  localparam int IRIN = 6, YIN = 7, ZIN = 8, ZLOW = 9, ZHIGH = 10, HIIN = 11, LOIN = 12;
  localparam int GRA = 13, GRB = 14, GRC = 15, RIN = 16, ROUT = 17, BAOUT = 18;
  localparam int COUT = 19, CONIN = 20, READ = 21, WRITE = 22, RUN = 23, FAULT = 24;

  logic [29:0] obs;
  assign obs = {alu_op, fault, Run, Write, Read, CONin, Cout, BAout, Rout, Rin, Grc, Grb, Gra,
                LOin, HIin, Zhighout, Zlowout, Zin, Yin, IRin, MDRout, MDRin, MARin, PCin,
                IncPC, PCout};

  typedef struct packed {
    logic [29:0] exp;
    logic        mr;
    logic        stop;
  } step_t;

  step_t steps[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [29:0] b(input int i);
    return 30'(1) << i;
  endfunction

  function automatic logic [29:0] alu(input logic [4:0] v);
    return {v, 25'b0};
  endfunction

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  task automatic check(input string tag, input logic [29:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [29:0] exp, input logic mr, input logic stop);
    steps.push_back('{exp: exp, mr: mr, stop: stop});
  endtask

  // Reference model: expected per-cycle outputs for one instruction, straight from the
  // class table. st1/stm are stall cycles in T1 and in the data-memory state.
  task automatic gen(input logic [4:0] op, input logic con, input int st1, input int stm,
                     input logic stop, output logic halts);
    logic [29:0] rn;
    logic [29:0] seq[$];
    int mem_i;
    logic flt;
    rn = b(RUN);
    halts = 1'b0;
    flt = 1'b0;
    mem_i = -1;
    steps.delete();
    push(rn | b(PCOUT) | b(MARIN) | b(INCPC), rnd(), rnd());
    if (st1 >= int'(WaitMax)) begin
      repeat (WaitMax) push(rn | b(READ) | b(MDRIN), 1'b0, rnd());
      halts = 1'b1;
      flt = 1'b1;
    end else begin
      repeat (st1) push(rn | b(READ) | b(MDRIN), 1'b0, rnd());
      push(rn | b(READ) | b(MDRIN), 1'b1, rnd());
      push(rn | b(MDROUT) | b(IRIN), rnd(), rnd());
      if (op <= 8) begin
        seq = '{b(GRB) | b(ROUT) | b(YIN), b(GRC) | b(ROUT) | b(ZIN) | alu(op),
                b(ZLOW) | b(GRA) | b(RIN)};
      end else if (op <= 11) begin
        seq = '{b(GRB) | b(ROUT) | b(YIN),
                b(COUT) | b(ZIN) | alu(op == 9 ? 5'd0 : (op == 10 ? 5'd2 : 5'd3)),
                b(ZLOW) | b(GRA) | b(RIN)};
      end else if (op == 12) begin
        seq = '{b(GRB) | b(BAOUT) | b(YIN), b(COUT) | b(ZIN), b(ZLOW) | b(MARIN),
                b(READ) | b(MDRIN), b(MDROUT) | b(GRA) | b(RIN)};
        mem_i = 3;
      end else if (op == 13) begin
        seq = '{b(GRB) | b(BAOUT) | b(YIN), b(COUT) | b(ZIN), b(ZLOW) | b(MARIN),
                b(GRA) | b(ROUT) | b(MDRIN), b(WRITE)};
        mem_i = 4;
      end else if (op == 14 || op == 15) begin
        seq = '{b(GRA) | b(ROUT) | b(YIN), b(GRB) | b(ROUT) | b(ZIN) | alu(op),
                b(ZLOW) | b(LOIN), b(ZHIGH) | b(HIIN)};
      end else if (op == 16) begin
        seq = '{b(GRA) | b(ROUT) | b(CONIN), b(PCOUT) | b(YIN), b(COUT) | b(ZIN),
                con ? (b(ZLOW) | b(PCIN)) : 30'b0};
      end else begin
        seq = '{30'b0};
      end
      for (int i = 0; i < seq.size(); i++) begin
        logic last;
        last = (i == seq.size() - 1);
        if (i == mem_i) begin
          repeat (stm) push(rn | seq[i], 1'b0, last ? 1'b0 : rnd());
          push(rn | seq[i], 1'b1, last ? stop : rnd());
        end else begin
          push(rn | seq[i], rnd(), last ? stop : rnd());
        end
      end
      halts = (op == 25) || stop;
    end
    if (halts) repeat (20) push(flt ? b(FAULT) : 30'b0, rnd(), rnd());
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear = 1'b0;
    #1 check("reset_async", 30'b0);
    @(negedge clock);
    check("reset_held", 30'b0);
    clear = 1'b1;
    #1 check("reset_rst", 30'b0);
    @(posedge clock);
  endtask

  task automatic do_instr(input logic [4:0] op, input logic con, input int st1, input int stm,
                          input logic stop, input logic abort);
    logic halts;
    logic [31:0] ir;
    int n;
    gen(op, con, st1, stm, stop, halts);
    ir = {op, 27'($urandom)};
    n = steps.size();
    if (abort) n = $urandom_range(0, steps.size() - 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      IR = ir;
      CON = con;
      mem_ready = steps[i].mr;
      Stop = steps[i].stop;
      #1 check($sformatf("op%0d_step%0d", op, i), steps[i].exp);
    end
    if (halts || abort) do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    do_instr(5'd0, 1'b0, 0, 0, 1'b0, 1'b0);   // add
    do_instr(5'd12, 1'b0, 0, 3, 1'b0, 1'b0);  // ld, 3 stalls in T6
    do_instr(5'd16, 1'b0, 0, 0, 1'b0, 1'b0);  // branch not taken
    do_instr(5'd16, 1'b1, 1, 0, 1'b0, 1'b0);  // branch taken
    do_instr(5'd14, 1'b0, 0, 0, 1'b0, 1'b0);  // mul
    do_instr(5'd13, 1'b0, 0, 2, 1'b0, 1'b0);  // st, 2 stalls in T7
    do_instr(5'd9, 1'b0, 0, 0, 1'b1, 1'b0);   // addi with Stop -> HALT
    do_instr(5'd0, 1'b0, 15, 0, 1'b0, 1'b0);  // T1 timeout -> fault
    do_instr(5'd11, 1'b0, 0, 0, 1'b0, 1'b0);  // fetch restarts after clear
    do_instr(5'd25, 1'b0, 0, 0, 1'b0, 1'b0);  // halt opcode
    do_instr(5'd24, 1'b0, 0, 0, 1'b0, 1'b0);  // nop
    do_instr(5'd12, 1'b0, 0, 14, 1'b1, 1'b0); // ld at max-1 stalls, then Stop
    for (int k = 0; k < 150; k++) begin
      logic [4:0] op;
      int st1;
      op  = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 16)) : 5'($urandom_range(0, 31));
      st1 = ($urandom_range(0, 19) == 0) ? int'(WaitMax) : int'($urandom_range(0, 3));
      do_instr(op, rnd(), st1, int'($urandom_range(0, 4)), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 9) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
